// File: rtl/result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : result_drain
//  Description : Drains finished FP16 result rows from one ping-pong group
//                of the result SRAM banks (group 0 = banks 8-11, group 1 =
//                banks 12-15) and emits them as an in-order 128-bit
//                valid/ready stream. Reads are credit-limited against a small
//                output FIFO, so fixed-latency SRAM returns always have room.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1          clock, rising edge
//    rst        in   1          asynchronous active-high reset
//    start      in   1          pulse: begin a drain (ignored while busy)
//    pingpang   in   1          bank group to drain, latched at start
//    num_rows   in   ADDR_W     addresses per bank, latched at start
//    brce       out  8          per-bank read enable, bit i = bank 8+i
//    braddr     out  ADDR_W     shared read address
//    brvalid    in   8          per-bank read-data valid
//    brdata     in   8*DATA_W   read data, bank 8+i on [i*DATA_W +: DATA_W]
//    out_valid  out  1          stream word valid
//    out_ready  in   1          stream consumer ready
//    out_data   out  DATA_W     stream word
//    out_last   out  1          final word of the drain
//    busy       out  1          drain in progress
//    done       out  1          one-cycle pulse when the drain completes
// ============================================================================
module result_drain #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pingpang,
    input  logic [ADDR_W-1:0]     num_rows,
    output logic [7:0]            brce,
    output logic [ADDR_W-1:0]     braddr,
    input  logic [7:0]            brvalid,
    input  logic [8*DATA_W-1:0]   brdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w:0]   c_depth_ext = (c_cnt_w + 1)'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_grp;
    logic [ADDR_W-1:0]    r_rows;
    logic [ADDR_W-1:0]    r_addr;
    logic [1:0]           r_bank;
    logic [ADDR_W+1:0]    r_last_idx;
    logic [ADDR_W+1:0]    r_pop_idx;
    logic [c_cnt_w-1:0]   r_inflight;
    logic [c_cnt_w-1:0]   r_fifo_cnt;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [DATA_W-1:0]    r_mem [FIFO_DEPTH];

    logic [c_cnt_w:0]     w_occ;
    logic                 w_issue;
    logic [3:0]           w_grp_valid;
    logic                 w_ret;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_W-1:0]    w_ret_data;

    // Every outstanding read already owns a FIFO slot, so a read is only
    // launched while FIFO entries plus reads in flight leave room.
    assign w_occ   = {1'b0, r_fifo_cnt} + {1'b0, r_inflight};
    assign w_issue = (r_state == S_ISSUE) && (w_occ < c_depth_ext);

    // Returns from the inactive group, or any return while idle (late data
    // from an aborted drain), are dropped here.
    assign w_grp_valid = (r_state == S_IDLE) ? 4'b0000
                       : (r_grp ? brvalid[7:4] : brvalid[3:0]);
    assign w_ret  = |w_grp_valid;
    assign w_push = w_ret && (r_fifo_cnt != c_depth);

    assign out_valid = (r_fifo_cnt != '0);
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_mem[r_rd_ptr];
    assign out_last  = out_valid && (r_pop_idx == r_last_idx);

    // One read is issued per cycle, so at most one bank returns per cycle.
    always_comb begin
        w_ret_data = '0;
        for (int i = 3; i >= 0; i--) begin
            if (w_grp_valid[i]) begin
                w_ret_data = brdata[(i + (r_grp ? 4 : 0)) * DATA_W +: DATA_W];
            end
        end
    end

    // Control FSM, read issue and in-flight accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grp      <= 1'b0;
            r_rows     <= '0;
            r_addr     <= '0;
            r_bank     <= 2'd0;
            r_last_idx <= '0;
            r_pop_idx  <= '0;
            r_inflight <= '0;
            brce       <= 8'd0;
            braddr     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            brce <= 8'd0;

            // Issue and return in the same cycle cancel out.
            if (w_issue && !(w_ret && r_inflight != '0)) begin
                r_inflight <= r_inflight + c_cnt_w'(1);
            end else if (!w_issue && w_ret && r_inflight != '0) begin
                r_inflight <= r_inflight - c_cnt_w'(1);
            end

            if (w_pop) begin
                r_pop_idx <= r_pop_idx + (ADDR_W + 2)'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_grp      <= pingpang;
                        r_rows     <= num_rows;
                        r_addr     <= '0;
                        r_bank     <= 2'd0;
                        r_pop_idx  <= '0;
                        r_last_idx <= {num_rows, 2'b00} - (ADDR_W + 2)'(1);
                        busy       <= 1'b1;
                        r_state    <= (num_rows == '0) ? S_FIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        brce   <= 8'd1 << {r_grp, r_bank};
                        braddr <= r_addr;
                        if (r_bank == 2'd3) begin
                            r_bank <= 2'd0;
                            if (r_addr == r_rows - ADDR_W'(1)) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_addr <= r_addr + ADDR_W'(1);
                            end
                        end else begin
                            r_bank <= r_bank + 2'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_inflight == '0 && r_fifo_cnt == '0) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_ret_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_result_drain
//  Description : Self-checking bench for result_drain. A latency-programmable
//                SRAM bank model answers reads; expected stream contents,
//                issue order and completion are derived from the drain rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_result_drain;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 pingpang = 1'b0;
    logic [ADDR_W-1:0]    num_rows = '0;
    logic [7:0]           brce;
    logic [ADDR_W-1:0]    braddr;
    logic [7:0]           brvalid = 8'd0;
    logic [8*DATA_W-1:0]  brdata = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [DATA_W-1:0]    out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    result_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pingpang(pingpang),
        .num_rows(num_rows), .brce(brce), .braddr(braddr), .brvalid(brvalid),
        .brdata(brdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drain configuration and scoreboard state
    int            cur_grp = 0;
    int            cur_n = 0;
    int            lat = 1;
    int            rmode = 0;      // 0 always ready, 1 random, 2 one 20-cycle stall
    bit            glitch_en = 1'b0;
    bit            mon_en = 1'b0;
    logic [31:0]   salt = 32'h0;
    logic [127:0]  exp_q[$];
    int            issued, popped, returned, done_cnt, done_cyc, start_cyc, stall_left;
    bit            prev_hold = 1'b0;
    logic [127:0]  prev_data;

    logic [7:0]        pipe_v [4] = '{default: 8'd0};
    logic [ADDR_W-1:0] pipe_a [4] = '{default: '0};

    // Content of SRAM bank (8+bank) at address addr for the current drain
    function automatic logic [127:0] word_of(input int bank, input int addr);
        logic [31:0] b;
        logic [31:0] a;
        b = bank;
        a = addr;
        return {salt, (b * 32'h9E3779B9) ^ a, a, ~salt ^ b};
    endfunction

    always @(negedge clk) begin
        logic [7:0]        v;
        logic [ADDR_W-1:0] a;
        logic [3:0]        g;
        logic [7:0]        eb;

        // SRAM model: a read seen with brce returns lat cycles later
        v = pipe_v[lat-1];
        a = pipe_a[lat-1];
        for (int k = 3; k > 0; k--) begin
            pipe_v[k] = pipe_v[k-1];
            pipe_a[k] = pipe_a[k-1];
        end
        pipe_v[0] = brce;
        pipe_a[0] = braddr;
        brvalid = v;
        for (int i = 0; i < 8; i++) begin
            brdata[i*DATA_W +: DATA_W] = v[i] ? word_of(i, int'(a)) : {4{$urandom}};
        end
        if (glitch_en && $urandom_range(0, 2) == 0) begin
            g = 4'($urandom);
            if (cur_grp == 1) brvalid[3:0] = brvalid[3:0] | g;
            else              brvalid[7:4] = brvalid[7:4] | g;
        end

        // Consumer
        if (rmode == 1)                                    out_ready = 1'($urandom_range(0, 1));
        else if (rmode == 2 && popped >= 5 && stall_left > 0) out_ready = 1'b0;
        else                                               out_ready = 1'b1;

        if (mon_en) begin
            if (prev_hold) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_data", out_data, prev_data);
            end
            if (brce != 8'd0) begin
                eb = 8'd1 << (cur_grp * 4 + issued % 4);
                check_val("issue_in_range", issued < 4 * cur_n, 1);
                check_val("brce", brce, eb);
                check_val("braddr", braddr, issued / 4);
                issued++;
            end
            check_val("credit", (issued - popped) <= DEPTH, 1);
            returned += $countones(cur_grp == 1 ? brvalid[7:4] : brvalid[3:0]);
            if (rmode == 2 && popped >= 5 && stall_left > 0) begin
                if (stall_left == 1) begin
                    check_val("bp_fifo_full", returned - popped, DEPTH);
                    check_val("bp_brce_idle", brce, 0);
                end
                stall_left--;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_word", 1, 0);
                end else begin
                    check_val("out_data", out_data, exp_q.pop_front());
                    check_val("out_last", out_last, popped == 4 * cur_n - 1);
                end
                popped++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_val("done_after_last", popped, 4 * cur_n);
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic run_drain(input int grp, input int n, input int l, input int mode,
                             input int gl, input int abort_at);
        int t;
        @(negedge clk);
        #1;
        cur_grp    = grp;
        cur_n      = n;
        lat        = l;
        rmode      = mode;
        glitch_en  = (gl != 0);
        salt       = $urandom;
        exp_q.delete();
        for (int a = 0; a < n; a++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(word_of(grp * 4 + b, a));
        issued = 0; popped = 0; returned = 0; done_cnt = 0; stall_left = 20;
        mon_en     = 1'b1;
        start      = 1'b1;
        pingpang   = grp[0];
        num_rows   = ADDR_W'(n);
        start_cyc  = cyc;
        // A second start cycle with different settings must be ignored
        @(negedge clk);
        #1;
        pingpang = ~pingpang;
        num_rows = num_rows + ADDR_W'(3);
        @(negedge clk);
        #1;
        start    = 1'b0;
        pingpang = 1'($urandom);
        num_rows = ADDR_W'($urandom);

        t = 0;
        while (done_cnt == 0 && !(abort_at >= 0 && popped >= abort_at) && t < 4000) begin
            @(negedge clk);
            #1;
            t++;
        end

        if (abort_at >= 0) begin
            check_val("abort_reached", popped >= abort_at, 1);
            rst = 1'b1;
            #1;
            check_val("rst_brce", brce, 0);
            check_val("rst_braddr", braddr, 0);
            check_val("rst_out_valid", out_valid, 0);
            check_val("rst_out_last", out_last, 0);
            check_val("rst_busy", busy, 0);
            check_val("rst_done", done, 0);
            mon_en = 1'b0;
            @(negedge clk);
            #1;
            rst = 1'b0;
            repeat (8) @(negedge clk);
            #1;
            check_val("late_dropped", out_valid, 0);
            check_val("idle_busy", busy, 0);
        end else begin
            check_val("done_seen", done_cnt, 1);
            repeat (4) @(negedge clk);
            #1;
            check_val("done_pulses", done_cnt, 1);
            check_val("words_total", popped, 4 * n);
            check_val("reads_total", issued, 4 * n);
            check_val("exp_left", exp_q.size(), 0);
            check_val("busy_end", busy, 0);
            check_val("valid_end", out_valid, 0);
            if (n == 0) check_val("n0_done_latency", done_cyc - start_cyc, 2);
            mon_en = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_brce", brce, 0);
        check_val("reset_braddr", braddr, 0);
        check_val("reset_out_valid", out_valid, 0);
        check_val("reset_out_data", out_data, 0);
        check_val("reset_out_last", out_last, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        rst = 1'b0;

        run_drain(0, 2, 1, 0, 0, -1);   // basic drain, lower group
        run_drain(1, 1, 1, 0, 1, -1);   // upper group with lower-group glitches
        run_drain(0, 8, 1, 2, 0, -1);   // 20-cycle backpressure stall
        run_drain(1, 6, 3, 1, 0, -1);   // latency 3, toggling ready
        run_drain(0, 0, 1, 0, 1, -1);   // empty drain
        run_drain(1, 4, 3, 1, 0, 5);    // reset after 5 words
        run_drain(0, 3, 2, 1, 0, -1);   // clean drain after reset
        for (int r = 0; r < 6; r++) begin
            run_drain($urandom_range(0, 1), $urandom_range(1, 5), $urandom_range(1, 3),
                      $urandom_range(0, 1), $urandom_range(0, 1), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
